prg_cache: RTL and testbench
============================

Name: prg_cache

Overview:
Direct-mapped, read-only program cache that answers the fetch unit's prg_address stream. It returns one instruction word per cycle on a hit. On a miss it asserts p_cache_miss and fills a whole line from external program memory through a req/ack handshake. It sits between the PC/fetch stage and the program memory bus, and is the source of the p_cache_miss signal that the PC consumes.

Parameters:
ADDR_W, 32, width of prg_address and mem_addr
DATA_W, 16, instruction word width
LINE_WORDS, 4, words per line (power of two, >=2)
LINES, 64, number of lines (power of two)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
prg_address  in  ADDR_W  fetch word address, sampled every clk
instruction  out  DATA_W  word for the address sampled on the previous edge
p_cache_miss  out  1  instruction is not valid this cycle
flush  in  1  invalidate all lines
mem_req  out  1  line-fill word request
mem_addr  out  ADDR_W  word address of the current fill request
mem_ack  in  1  mem_data valid; current request is complete
mem_data  in  DATA_W  fill word

Behaviour:
- Address split, from the LSB up:
  - OFF = log2(LINE_WORDS) bits
  - IDX = log2(LINES) bits
  - TAG = remaining bits
- Storage:
  - valid[LINES] held in flops
  - tag and data arrays with registered read
- State machine has three states: LOOKUP, FILL, RESUME.
- Reset:
  - state = LOOKUP; all valid bits cleared; lookup_live = 0
  - instruction = 0, p_cache_miss = 0, mem_req = 0, mem_addr = 0
  - fill word counter = 0, flush_pending = 0
- Lookup timing:
  - In LOOKUP and RESUME, prg_address is registered on every edge as addr_q. Data and tag are read in the same edge.
  - lookup_live is set on the first edge after reset release and stays set.
  - hit = lookup_live & valid[addr_q.IDX] & (tag == addr_q.TAG).
- p_cache_miss is combinational:
  - (state==LOOKUP & lookup_live & ~hit) | state==FILL | state==RESUME.
  - It is 0 in the first cycle after reset.
- Hit latency is 1 cycle: address at edge N gives instruction valid after edge N with p_cache_miss=0. Back-to-back hits give one word per cycle.
- Miss (LOOKUP & ~hit):
  - Latch miss_addr = addr_q, word counter = 0.
  - On the next edge go to FILL with mem_req=1 and mem_addr = {miss TAG, miss IDX, OFF=0}.
- FILL:
  - mem_req stays high.
  - Each cycle with mem_ack: write mem_data into data[IDX][counter], increment counter, and advance mem_addr to the next word on the same edge.
  - mem_req remains high between words. Wait cycles of any length (mem_ack=0) are legal.
  - On the ack of the last word (counter == LINE_WORDS-1):
    - mem_req drops to 0 on that edge.
    - Write the tag.
    - Set valid[IDX] unless flush_pending.
    - Go to RESUME.
- RESUME:
  - Lasts one cycle. p_cache_miss=1.
  - prg_address (held by the fetch unit at the miss address) is re-read.
  - Next state is LOOKUP, where hit/miss is evaluated normally.
  - The first word after a completed fill therefore arrives 2 cycles after the final mem_ack.
- prg_address changes during FILL are ignored; only RESUME re-samples.
- flush:
  - In LOOKUP or RESUME: clear all valid bits on that edge. A lookup on the same edge sees them cleared on the following cycle.
  - In FILL: set flush_pending. The fill still completes, but the line is not validated; all valids are cleared when FILL exits, and flush_pending is cleared at the same time.
- Fill writes never touch other lines. A miss to index i evicts the line at i unconditionally.
- Reset asserted mid-fill:
  - Immediately mem_req=0, state=LOOKUP, all valid cleared.
  - The partially written line stays invalid.
  - A late mem_ack after reset is ignored.
- mem_ack while mem_req=0 is ignored.

Test Plan:
- Reset release, prg_address=0x0000 with an empty cache -> p_cache_miss=1 on cycle 2. mem_req=1 with mem_addr=0,1,2,3. After the 4th ack: RESUME, then instruction=mem word 0, p_cache_miss=0.
- After filling line 0 (data 0xA000..0xA003), drive addresses 0,1,2,3 on consecutive cycles -> 4 consecutive hits, instruction=0xA000..0xA003, p_cache_miss stays 0.
- Fill 0x0000, then access 0x0100 (same IDX, different TAG) -> miss and refill. A later access to 0x0000 misses again (eviction).
- Fill with 3 wait cycles between each ack -> mem_addr is held during waits, p_cache_miss is held 1, and the final data is correct.
- flush pulsed during FILL of 0x0040 -> fill completes, but a re-access to 0x0040 in LOOKUP misses. A previously valid line 0x0000 also misses.
- rst asserted after 2 of 4 acks -> mem_req=0 immediately. After release, 0x0000 misses again and refetches all 4 words.

Source files
------------

// File: rtl/prg_cache.sv
// Direct-mapped read-only program cache between the fetch stage and program memory.
// Hits return one word per cycle; a miss refills the whole line over a req/ack handshake.
module prg_cache #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 16,
  parameter int LINE_WORDS = 4,
  parameter int LINES      = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] prg_address,
  output logic [DATA_W-1:0] instruction,
  output logic              p_cache_miss,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    ST_LOOKUP = 2'd0,
    ST_FILL   = 2'd1,
    ST_RESUME = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [DATA_W-1:0] r_data_mem [LINES*LINE_WORDS];
  logic [TAG_W-1:0]  r_tag_mem  [LINES];
  logic [LINES-1:0]  r_valid;

  logic              r_lookup_live;
  logic [IDX_W-1:0]  r_addr_idx;
  logic [TAG_W-1:0]  r_addr_tag;
  logic [TAG_W-1:0]  r_tag_q;
  logic [DATA_W-1:0] r_instr;
  logic [IDX_W-1:0]  r_miss_idx;
  logic [TAG_W-1:0]  r_miss_tag;
  logic [OFF_W-1:0]  r_word_cnt;
  logic              r_flush_pending;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;

  logic              w_sample;
  logic              w_hit;
  logic              w_miss;
  logic              w_ack;
  logic              w_last;
  logic [TAG_W-1:0]  w_in_tag;
  logic [IDX_W-1:0]  w_in_idx;
  logic [OFF_W-1:0]  w_in_off;

  assign w_in_tag = prg_address[ADDR_W-1 -: TAG_W];
  assign w_in_idx = prg_address[OFF_W +: IDX_W];
  assign w_in_off = prg_address[OFF_W-1:0];

  always_comb begin
    w_sample     = 1'b0;
    w_miss       = 1'b0;
    w_ack        = 1'b0;
    w_last       = 1'b0;
    w_next_state = r_state;
    w_hit        = r_lookup_live & r_valid[r_addr_idx] & (r_tag_q == r_addr_tag);
    case (r_state)
      ST_LOOKUP: begin
        w_sample = 1'b1;
        w_miss   = r_lookup_live & ~w_hit;
        if (w_miss) w_next_state = ST_FILL;
        else        w_next_state = ST_LOOKUP;
      end
      ST_FILL: begin
        w_ack  = mem_ack;
        w_last = mem_ack & (r_word_cnt == LAST_OFF);
        if (w_last) w_next_state = ST_RESUME;
        else        w_next_state = ST_FILL;
      end
      ST_RESUME: begin
        w_sample     = 1'b1;
        w_next_state = ST_LOOKUP;
      end
      default: w_next_state = ST_LOOKUP;
    endcase
  end

  assign p_cache_miss = w_miss | (r_state == ST_FILL) | (r_state == ST_RESUME);
  assign instruction  = r_instr;
  assign mem_req      = r_mem_req;
  assign mem_addr     = r_mem_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_LOOKUP;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lookup_live   <= 1'b0;
      r_addr_idx      <= '0;
      r_addr_tag      <= '0;
      r_tag_q         <= '0;
      r_instr         <= '0;
      r_valid         <= '0;
      r_miss_idx      <= '0;
      r_miss_tag      <= '0;
      r_word_cnt      <= '0;
      r_flush_pending <= 1'b0;
      r_mem_req       <= 1'b0;
      r_mem_addr      <= '0;
    end else begin
      r_lookup_live <= 1'b1;
      if (w_sample) begin
        r_addr_idx <= w_in_idx;
        r_addr_tag <= w_in_tag;
        r_tag_q    <= r_tag_mem[w_in_idx];
        r_instr    <= r_data_mem[{w_in_idx, w_in_off}];
      end
      // A flush seen during the fill (even on its last ack) leaves the cache fully invalid.
      if (flush && r_state != ST_FILL) begin
        r_valid <= '0;
      end else if (w_miss) begin
        r_valid[r_addr_idx] <= 1'b0;
      end else if (w_last) begin
        if (r_flush_pending || flush) r_valid <= '0;
        else                          r_valid[r_miss_idx] <= 1'b1;
      end
      if (r_state == ST_FILL && !w_last) begin
        r_flush_pending <= r_flush_pending | flush;
      end else begin
        r_flush_pending <= 1'b0;
      end
      if (w_miss) begin
        r_miss_idx <= r_addr_idx;
        r_miss_tag <= r_addr_tag;
        r_word_cnt <= '0;
        r_mem_req  <= 1'b1;
        r_mem_addr <= {r_addr_tag, r_addr_idx, {OFF_W{1'b0}}};
      end else if (w_ack) begin
        r_word_cnt <= r_word_cnt + OFF_W'(1);
        r_mem_addr <= r_mem_addr + ADDR_W'(1);
        if (w_last) r_mem_req <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_ack) r_data_mem[{r_miss_idx, r_word_cnt}] <= mem_data;
    if (w_last) r_tag_mem[r_miss_idx] <= r_miss_tag;
  end
endmodule

// File: tb/tb_prg_cache.sv
// Directed plus randomized bench for prg_cache against an abstract line-tag cache model
// and a deterministic backing program memory.
module tb_prg_cache;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] prg_address;
  logic [15:0] instruction;
  logic        p_cache_miss;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;

  prg_cache #(.ADDR_W(32), .DATA_W(16), .LINE_WORDS(4), .LINES(64)) dut (
    .clk(clk), .rst(rst), .prg_address(prg_address), .instruction(instruction),
    .p_cache_miss(p_cache_miss), .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit          model_valid [64];
  logic [23:0] model_tag   [64];
  logic [31:0] a;
  int          wt;
  bit          aborted;

  function automatic logic [15:0] backing(input logic [31:0] addr);
    if (addr < 32'd4) return 16'hA000 + addr[15:0];
    else              return (addr[15:0] * 16'h9E37) ^ addr[31:16] ^ 16'h3C5A;
  endfunction

  function automatic bit model_hit(input logic [31:0] addr);
    return model_valid[addr[7:2]] && (model_tag[addr[7:2]] == addr[31:8]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) model_valid[i] = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Entered at the negedge where the miss is visible; leaves at the RESUME negedge.
  task automatic fill_line(input logic [31:0] addr, input int waits, input int flush_at,
                           input int rst_after, output bit abort);
    logic [31:0] base;
    base  = addr & ~32'd3;
    abort = 1'b0;
    chk("req_idle", 32'(mem_req), 32'd0);
    @(posedge clk); @(negedge clk);
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < waits; k++) begin
        chk("wait_req", 32'(mem_req), 32'd1);
        chk("wait_addr", mem_addr, base + 32'(w));
        chk("wait_miss", 32'(p_cache_miss), 32'd1);
        prg_address = $urandom;
        @(posedge clk); @(negedge clk);
      end
      if (w == rst_after) begin
        rst = 1'b1;
        #1;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_miss", 32'(p_cache_miss), 32'd0);
        model_clear();
        abort = 1'b1;
        return;
      end
      chk("fill_req", 32'(mem_req), 32'd1);
      chk("fill_addr", mem_addr, base + 32'(w));
      chk("fill_miss", 32'(p_cache_miss), 32'd1);
      mem_ack     = 1'b1;
      mem_data    = backing(base + 32'(w));
      flush       = (w == flush_at);
      prg_address = $urandom;
      @(posedge clk); @(negedge clk);
      mem_ack  = 1'b0;
      mem_data = 16'($urandom);
      flush    = 1'b0;
    end
    chk("resume_miss", 32'(p_cache_miss), 32'd1);
    chk("resume_req", 32'(mem_req), 32'd0);
    if (flush_at >= 0) begin
      model_clear();
    end else begin
      model_valid[addr[7:2]] = 1'b1;
      model_tag[addr[7:2]]   = addr[31:8];
    end
    prg_address = addr;
  endtask

  task automatic access(input logic [31:0] addr, input int waits, input int flush_at,
                        input bit flush_lookup);
    bit exp_hit;
    bit ab;
    int fa;
    fa          = flush_at;
    prg_address = addr;
    flush       = flush_lookup;
    for (int it = 0; it < 3; it++) begin
      @(posedge clk); @(negedge clk);
      flush   = 1'b0;
      mem_ack = 1'b0;
      if (flush_lookup && it == 0) model_clear();
      exp_hit = model_hit(addr);
      chk("miss_flag", 32'(p_cache_miss), 32'(!exp_hit));
      if (exp_hit) begin
        chk("instr", 32'(instruction), 32'(backing(addr)));
        return;
      end
      fill_line(addr, waits, fa, -1, ab);
      fa = -1;
    end
  endtask

  initial begin
    rst = 1'b1; prg_address = 32'd0; flush = 1'b0; mem_ack = 1'b0; mem_data = 16'd0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_instr", 32'(instruction), 32'd0);
    chk("rst_miss0", 32'(p_cache_miss), 32'd0);
    chk("rst_req0", 32'(mem_req), 32'd0);
    chk("rst_addr0", mem_addr, 32'd0);
    rst = 1'b0;
    chk("first_cycle_miss", 32'(p_cache_miss), 32'd0);

    access(32'h0, 0, -1, 1'b0);
    for (int i = 0; i < 4; i++) access(32'(i), 0, -1, 1'b0);

    access(32'h100, 0, -1, 1'b0);
    access(32'h102, 0, -1, 1'b0);
    access(32'h0, 0, -1, 1'b0);

    access(32'h2345, 3, -1, 1'b0);
    access(32'h2346, 0, -1, 1'b0);

    access(32'h40, 0, 1, 1'b0);
    access(32'h0, 0, -1, 1'b0);
    access(32'h41, 0, -1, 1'b1);

    for (int n = 0; n < 40; n++) begin
      a  = 32'($urandom_range(0, 767));
      wt = $urandom_range(0, 2);
      access(a, wt, -1, ($urandom_range(0, 9) == 0));
    end

    access(32'h0, 0, -1, 1'b0);
    prg_address = 32'h80;
    @(posedge clk); @(negedge clk);
    chk("rst_seq_miss", 32'(p_cache_miss), 32'd1);
    fill_line(32'h80, 0, -1, 2, aborted);
    chk("aborted", 32'(aborted), 32'd1);
    mem_ack  = 1'b1;
    mem_data = 16'hDEAD;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("post_rst_req", 32'(mem_req), 32'd0);
    chk("post_rst_miss", 32'(p_cache_miss), 32'd0);
    access(32'h0, 0, -1, 1'b0);
    access(32'h80, 1, -1, 1'b0);
    access(32'h83, 0, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
